// File: rtl/load_store_unit.sv
// load_store_unit: memory-stage block that runs one load or store at a time
// against a request/grant + response-valid data memory port.
// Optional build macro LSU_MISALIGN_TRAP_EN: misaligned H/W accesses complete
// immediately with misalign_o=1 and never reach the memory.
module load_store_unit #(
    parameter int AWIDTH = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ex_valid_i,
    output logic              ex_ready_o,
    input  logic [AWIDTH-1:0] addr_i,
    input  logic [31:0]       wdata_i,
    input  logic [2:0]        funct3_i,
    input  logic              memread_i,
    input  logic              memwrite_i,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [AWIDTH-1:0] mem_addr_o,
    output logic [31:0]       mem_wdata_o,
    output logic [3:0]        mem_wstrb_o,
    input  logic              mem_gnt_i,
    input  logic              mem_rvalid_i,
    input  logic [31:0]       mem_rdata_i,
    output logic              done_o,
    output logic [31:0]       load_data_o,
    output logic              misalign_o
);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;
    typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W} size_t;

    // funct3[1:0] alone gives the access size; 011/110/111 fall into word.
    function automatic size_t size_of(input logic [2:0] f);
        case (f[1:0])
            2'b00:   return SZ_B;
            2'b01:   return SZ_H;
            default: return SZ_W;
        endcase
    endfunction

    state_t            state, state_next;
    logic [AWIDTH-1:0] addr_q;
    logic [2:0]        funct3_q;
    logic              we_q;
    logic [31:0]       wdata_q;
    logic [3:0]        wstrb_q;
    logic [31:0]       load_q;

    logic        accept;
    logic [31:0] lane_wdata;
    logic [3:0]  lane_wstrb;
    logic [7:0]  rd_byte;
    logic [15:0] rd_half;
    logic [31:0] rd_ext;

    assign accept = ex_valid_i && (state == S_IDLE) && (memread_i || memwrite_i);

`ifdef LSU_MISALIGN_TRAP_EN
    logic misalign_q;
    logic misaligned_in;

    assign misaligned_in = ((size_of(funct3_i) == SZ_H) && addr_i[0]) ||
                           ((size_of(funct3_i) == SZ_W) && (addr_i[1:0] != 2'b00));
    assign misalign_o    = misalign_q;
`else
    assign misalign_o    = 1'b0;
`endif

    // Position store data and byte enables on the lanes picked by the address.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so no latch is inferred.
        lane_wdata = wdata_i;
        lane_wstrb = 4'b1111;
        case (size_of(funct3_i))
            SZ_B: begin
                lane_wdata = {4{wdata_i[7:0]}};
                lane_wstrb = 4'b0001 << addr_i[1:0];
            end
            SZ_H: begin
                lane_wdata = {2{wdata_i[15:0]}};
                lane_wstrb = 4'b0011 << {addr_i[1], 1'b0};
            end
            default: ;
        endcase
    end

    // Pull the addressed byte/half out of the read word and extend it.
    always_comb begin
        rd_byte = mem_rdata_i[7:0];
        case (addr_q[1:0])
            2'd1:    rd_byte = mem_rdata_i[15:8];
            2'd2:    rd_byte = mem_rdata_i[23:16];
            2'd3:    rd_byte = mem_rdata_i[31:24];
            default: ;
        endcase
        rd_half = addr_q[1] ? mem_rdata_i[31:16] : mem_rdata_i[15:0];
        case (size_of(funct3_q))
            SZ_B:    rd_ext = {{24{~funct3_q[2] & rd_byte[7]}}, rd_byte};
            SZ_H:    rd_ext = {{16{~funct3_q[2] & rd_half[15]}}, rd_half};
            default: rd_ext = mem_rdata_i;
        endcase
    end

    // Next-state logic for the one-access-at-a-time handshake.
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (accept) begin
`ifdef LSU_MISALIGN_TRAP_EN
                    state_next = misaligned_in ? S_DONE : S_REQ;
`else
                    state_next = S_REQ;
`endif
                end
            end
            S_REQ:   if (mem_gnt_i) state_next = we_q ? S_DONE : S_WAIT;
            S_WAIT:  if (mem_rvalid_i) state_next = S_DONE;
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // State register; synchronous reset abandons any access in flight.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (reset) state <= S_IDLE;
        else       state <= state_next;
    end

    // Capture the operation on accept and the load result on rvalid.
    always_ff @(posedge clk) begin
        if (reset) begin
            addr_q   <= '0;
            funct3_q <= '0;
            we_q     <= 1'b0;
            wdata_q  <= '0;
            wstrb_q  <= '0;
            load_q   <= '0;
        end else begin
            if (accept) begin
                addr_q   <= addr_i;
                funct3_q <= funct3_i;
                we_q     <= memwrite_i;
                wdata_q  <= lane_wdata;
                wstrb_q  <= lane_wstrb;
`ifdef LSU_MISALIGN_TRAP_EN
                if (misaligned_in) load_q <= '0;
`endif
            end
            if (state == S_REQ && mem_gnt_i && we_q) load_q <= '0;
            if (state == S_WAIT && mem_rvalid_i)     load_q <= rd_ext;
        end
    end

`ifdef LSU_MISALIGN_TRAP_EN
    // Misalignment flag is decided at accept and held until the next accept.
    always_ff @(posedge clk) begin
        if (reset)       misalign_q <= 1'b0;
        else if (accept) misalign_q <= misaligned_in;
    end
`endif

    assign ex_ready_o  = (state == S_IDLE);
    assign mem_req_o   = (state == S_REQ);
    assign done_o      = (state == S_DONE);
    assign mem_we_o    = we_q;
    assign mem_addr_o  = {addr_q[AWIDTH-1:2], 2'b00};
    assign mem_wdata_o = wdata_q;
    assign mem_wstrb_o = wstrb_q;
    assign load_data_o = load_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Testbench for load_store_unit: table of directed vectors, hand-written
// corner sequences, then randomized accesses checked against a byte-level model.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        ex_valid_i;
    logic        ex_ready_o;
    logic [31:0] addr_i;
    logic [31:0] wdata_i;
    logic [2:0]  funct3_i;
    logic        memread_i;
    logic        memwrite_i;
    logic        mem_req_o;
    logic        mem_we_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic [3:0]  mem_wstrb_o;
    logic        mem_gnt_i;
    logic        mem_rvalid_i;
    logic [31:0] mem_rdata_i;
    logic        done_o;
    logic [31:0] load_data_o;
    logic        misalign_o;

    int n_checks = 0;
    int n_pass   = 0;

    load_store_unit #(.AWIDTH(32)) dut (
        .clk          (clk),
        .reset        (reset),
        .ex_valid_i   (ex_valid_i),
        .ex_ready_o   (ex_ready_o),
        .addr_i       (addr_i),
        .wdata_i      (wdata_i),
        .funct3_i     (funct3_i),
        .memread_i    (memread_i),
        .memwrite_i   (memwrite_i),
        .mem_req_o    (mem_req_o),
        .mem_we_o     (mem_we_o),
        .mem_addr_o   (mem_addr_o),
        .mem_wdata_o  (mem_wdata_o),
        .mem_wstrb_o  (mem_wstrb_o),
        .mem_gnt_i    (mem_gnt_i),
        .mem_rvalid_i (mem_rvalid_i),
        .mem_rdata_i  (mem_rdata_i),
        .done_o       (done_o),
        .load_data_o  (load_data_o),
        .misalign_o   (misalign_o)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual === expected) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, actual, expected);
    endtask

    // Advance one clock; outputs are then sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // ---------------- reference model (byte arithmetic) ----------------
    function automatic int nbytes(input logic [2:0] f);
        case (f)
            3'b000, 3'b100: return 1;
            3'b001, 3'b101: return 2;
            default:        return 4;
        endcase
    endfunction

    function automatic int lane_off(input logic [2:0] f, input logic [31:0] a);
        int n = nbytes(f);
        return (int'(a[1:0]) / n) * n;
    endfunction

    function automatic logic [3:0] m_wstrb(input logic [2:0] f, input logic [31:0] a);
        int n = nbytes(f);
        logic [7:0] m = 8'(((1 << n) - 1) << lane_off(f, a));
        return m[3:0];
    endfunction

    function automatic logic [31:0] m_wdata(input logic [2:0] f, input logic [31:0] wd);
        logic [31:0] r;
        int n = nbytes(f);
        for (int k = 0; k < 4; k++) r[8*k +: 8] = wd[8*(k % n) +: 8];
        return r;
    endfunction

    function automatic logic [31:0] m_load(input logic [2:0] f, input logic [31:0] a, input logic [31:0] rd);
        int n = nbytes(f);
        logic [31:0] v, mask;
        if (n == 4) return rd;
        mask = 32'((64'd1 << (8 * n)) - 64'd1);
        v = (rd >> (8 * lane_off(f, a))) & mask;
        if (!f[2] && v[8*n-1]) v = v | ~mask;
        return v;
    endfunction

    function automatic bit is_misaligned(input logic [2:0] f, input logic [31:0] a);
        int n = nbytes(f);
        return (n > 1) && ((int'(a[1:0]) % n) != 0);
    endfunction

    // ---------------- one complete access ----------------
    task automatic access(input string nm, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] wd, input logic [31:0] rd, input bit wr,
                          input bit both, input int gd, input int rvd,
                          input logic [3:0] ewstrb, input logic [31:0] ewdata,
                          input logic [31:0] eload);
        ex_valid_i = 1'b1; addr_i = a; wdata_i = wd; funct3_i = f3;
        memwrite_i = wr; memread_i = !wr || both;
        check({nm, ".ready_idle"}, ex_ready_o, 1);
        step();
        ex_valid_i = 1'b0; memread_i = 1'b0; memwrite_i = 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
        if (is_misaligned(f3, a)) begin
            check({nm, ".trap_req"}, mem_req_o, 0);
            check({nm, ".trap_done"}, done_o, 1);
            check({nm, ".trap_flag"}, misalign_o, 1);
            check({nm, ".trap_load"}, load_data_o, 0);
            step();
            check({nm, ".trap_req2"}, mem_req_o, 0);
            check({nm, ".trap_done_end"}, done_o, 0);
            check({nm, ".trap_ready_end"}, ex_ready_o, 1);
            return;
        end
`endif
        for (int c = 0; c <= gd; c++) begin
            check({nm, ".req"}, mem_req_o, 1);
            check({nm, ".ready_busy"}, ex_ready_o, 0);
            check({nm, ".done_early"}, done_o, 0);
            check({nm, ".addr"}, mem_addr_o, a & ~32'h3);
            check({nm, ".we"}, mem_we_o, wr);
            if (wr) begin
                check({nm, ".wstrb"}, mem_wstrb_o, ewstrb);
                check({nm, ".wdata"}, mem_wdata_o, ewdata);
            end
            if (c == gd) mem_gnt_i = 1'b1;
            step();
            mem_gnt_i = 1'b0;
        end
        check({nm, ".req_drop"}, mem_req_o, 0);
        if (wr) begin
            check({nm, ".done"}, done_o, 1);
            check({nm, ".ready_done"}, ex_ready_o, 0);
            check({nm, ".store_load0"}, load_data_o, 0);
            check({nm, ".misalign"}, misalign_o, 0);
        end else begin
            for (int c = 0; c < rvd; c++) begin
                check({nm, ".done_wait"}, done_o, 0);
                step();
            end
            check({nm, ".done_wait"}, done_o, 0);
            mem_rvalid_i = 1'b1; mem_rdata_i = rd;
            step();
            mem_rvalid_i = 1'b0; mem_rdata_i = $urandom;
            check({nm, ".done"}, done_o, 1);
            check({nm, ".load"}, load_data_o, eload);
            check({nm, ".misalign"}, misalign_o, 0);
        end
        step();
        check({nm, ".done_pulse"}, done_o, 0);
        check({nm, ".ready_end"}, ex_ready_o, 1);
        check({nm, ".load_hold"}, load_data_o, wr ? 32'h0 : eload);
    endtask

    typedef struct {
        string       name;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        bit          wr;
        bit          both;
        int          gd;
        int          rvd;
        logic [3:0]  exp_wstrb;
        logic [31:0] exp_wdata;
        logic [31:0] exp_load;
    } vec_t;

    vec_t vecs[10];

    initial begin
        vecs[0] = '{"sw",       3'b010, 32'h100, 32'hDEADBEEF, 32'h0,        1, 0, 0, 0, 4'b1111, 32'hDEADBEEF, 32'h0};
        vecs[1] = '{"sb",       3'b000, 32'h103, 32'h000000A5, 32'h0,        1, 0, 0, 0, 4'b1000, 32'hA5A5A5A5, 32'h0};
        vecs[2] = '{"lb",       3'b000, 32'h102, 32'h0,        32'h12C0FF34, 0, 0, 0, 3, 4'b0000, 32'h0,        32'hFFFFFFC0};
        vecs[3] = '{"lbu",      3'b100, 32'h102, 32'h0,        32'h12C0FF34, 0, 0, 0, 3, 4'b0000, 32'h0,        32'h000000C0};
        vecs[4] = '{"lhu",      3'b101, 32'h102, 32'h0,        32'h12C0FF34, 0, 0, 0, 3, 4'b0000, 32'h0,        32'h000012C0};
        vecs[5] = '{"lh",       3'b001, 32'h100, 32'h0,        32'h12C0FF34, 0, 0, 1, 0, 4'b0000, 32'h0,        32'hFFFFFF34};
        vecs[6] = '{"sh",       3'b001, 32'h202, 32'h1234ABCD, 32'h0,        1, 0, 0, 0, 4'b1100, 32'hABCDABCD, 32'h0};
        vecs[7] = '{"sw_wait4", 3'b010, 32'h340, 32'h01020304, 32'h0,        1, 0, 4, 0, 4'b1111, 32'h01020304, 32'h0};
        vecs[8] = '{"both_st",  3'b000, 32'h011, 32'h0000005A, 32'h0,        1, 1, 0, 0, 4'b0010, 32'h5A5A5A5A, 32'h0};
        vecs[9] = '{"lw_mis",   3'b010, 32'h102, 32'h0,        32'hCAFEF00D, 0, 0, 0, 0, 4'b0000, 32'h0,        32'hCAFEF00D};

        ex_valid_i = 0; addr_i = 0; wdata_i = 0; funct3_i = 0; memread_i = 0; memwrite_i = 0;
        mem_gnt_i = 0; mem_rvalid_i = 0; mem_rdata_i = 0;
        reset = 1'b1;
        step(); step();
        reset = 1'b0;
        check("rst.ready", ex_ready_o, 1);
        check("rst.req", mem_req_o, 0);
        check("rst.we", mem_we_o, 0);
        check("rst.addr", mem_addr_o, 0);
        check("rst.wdata", mem_wdata_o, 0);
        check("rst.wstrb", mem_wstrb_o, 0);
        check("rst.done", done_o, 0);
        check("rst.load", load_data_o, 0);
        check("rst.misalign", misalign_o, 0);

        for (int i = 0; i < 10; i++)
            access(vecs[i].name, vecs[i].f3, vecs[i].addr, vecs[i].wdata, vecs[i].rdata,
                   vecs[i].wr, vecs[i].both, vecs[i].gd, vecs[i].rvd,
                   vecs[i].exp_wstrb, vecs[i].exp_wdata, vecs[i].exp_load);

        // ex_valid with neither direction flag is ignored.
        ex_valid_i = 1'b1; addr_i = 32'h500;
        step();
        ex_valid_i = 1'b0;
        check("noop.req", mem_req_o, 0);
        check("noop.ready", ex_ready_o, 1);
        step();
        check("noop.req2", mem_req_o, 0);

        // Spurious rvalid while idle produces no completion.
        mem_rvalid_i = 1'b1; mem_rdata_i = 32'hFFFF_FFFF;
        step();
        mem_rvalid_i = 1'b0;
        check("spur.done", done_o, 0);
        step();
        check("spur.done2", done_o, 0);
        check("spur.ready", ex_ready_o, 1);

        // Reset while waiting for read data; a late rvalid must be ignored.
        ex_valid_i = 1'b1; addr_i = 32'h600; funct3_i = 3'b010; memread_i = 1'b1;
        step();
        ex_valid_i = 1'b0; memread_i = 1'b0;
        check("rstw.req", mem_req_o, 1);
        mem_gnt_i = 1'b1;
        step();
        mem_gnt_i = 1'b0;
        step();
        check("rstw.in_wait", done_o | mem_req_o | ex_ready_o, 0);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("rstw.ready", ex_ready_o, 1);
        check("rstw.req", mem_req_o, 0);
        check("rstw.done", done_o, 0);
        mem_rvalid_i = 1'b1; mem_rdata_i = 32'h1357_9BDF;
        step();
        mem_rvalid_i = 1'b0;
        check("rstw.late_done", done_o, 0);
        check("rstw.late_load", load_data_o, 0);
        step();
        check("rstw.late_done2", done_o, 0);
        check("rstw.late_req", mem_req_o, 0);

        // Randomized accesses checked against the byte-level model.
        for (int i = 0; i < 60; i++) begin
            logic [2:0]  ld_f3[8];
            logic [2:0]  st_f3[6];
            logic [2:0]  f;
            logic [31:0] a, wd, rd;
            bit          wr;
            ld_f3 = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101, 3'b011, 3'b110, 3'b111};
            st_f3 = '{3'b000, 3'b001, 3'b010, 3'b011, 3'b110, 3'b111};
            wr = 1'($urandom_range(0, 1));
            f  = wr ? st_f3[$urandom_range(0, 5)] : ld_f3[$urandom_range(0, 7)];
            a  = $urandom; wd = $urandom; rd = $urandom;
            access("rnd", f, a, wd, rd, wr, 1'($urandom_range(0, 1)),
                   int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                   m_wstrb(f, a), m_wdata(f, wd), m_load(f, a, rd));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
